// File: rtl/priority_frame_scheduler.sv
// Frame-atomic strict-priority scheduler for three AXI-Stream queues
// with starvation promotion and a registered output stage.
module priority_frame_scheduler #(
    parameter int AXIS_DATA_WIDTH  = 64,
    parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
    parameter int STARVE_LIMIT     = 8,
    parameter int STARVE_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_q0_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_q0_tkeep,
    input  logic                       s_axis_q0_tvalid,
    output logic                       s_axis_q0_tready,
    input  logic                       s_axis_q0_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_q1_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_q1_tkeep,
    input  logic                       s_axis_q1_tvalid,
    output logic                       s_axis_q1_tready,
    input  logic                       s_axis_q1_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_q2_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_q2_tkeep,
    input  logic                       s_axis_q2_tvalid,
    output logic                       s_axis_q2_tready,
    input  logic                       s_axis_q2_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [1:0]                 status_grant,
    output logic                       status_busy,
    output logic                       status_starve_event
);

    localparam int CW = STARVE_CNT_WIDTH;
    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {ARB, TRANSFER} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 grant_q, grant_d;
    logic [CW-1:0]              cnt_q [3];
    logic [CW-1:0]              cnt_d [3];
    logic                       starve_q, starve_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic [AXIS_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [AXIS_KEEP_WIDTH-1:0] out_keep_q, out_keep_d;

    logic [2:0]                 q_valid;
    logic [1:0]                 pick;
    logic                       pick_forced;
    logic                       sel_valid;
    logic                       sel_last;
    logic [AXIS_DATA_WIDTH-1:0] sel_data;
    logic [AXIS_KEEP_WIDTH-1:0] sel_keep;
    logic                       xfer_ready;
    logic                       load;

    assign q_valid = {s_axis_q2_tvalid, s_axis_q1_tvalid, s_axis_q0_tvalid};

    // Register may accept a beat whenever it is empty or draining this cycle.
    assign xfer_ready = (state_q == TRANSFER) & (~out_valid_q | m_axis_tready);

    assign s_axis_q0_tready = xfer_ready & (grant_q == 2'd0);
    assign s_axis_q1_tready = xfer_ready & (grant_q == 2'd1);
    assign s_axis_q2_tready = xfer_ready & (grant_q == 2'd2);

    always_comb begin
        pick        = 2'd2;
        pick_forced = 1'b0;
        if (q_valid[1] && cnt_q[1] >= LIMIT) begin
            pick        = 2'd1;
            pick_forced = 1'b1;
        end else if (q_valid[2] && cnt_q[2] >= LIMIT) begin
            pick        = 2'd2;
            pick_forced = 1'b1;
        end else if (q_valid[0]) begin
            pick = 2'd0;
        end else if (q_valid[1]) begin
            pick = 2'd1;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        case (grant_q)
            2'd0: begin
                sel_valid = s_axis_q0_tvalid;
                sel_last  = s_axis_q0_tlast;
                sel_data  = s_axis_q0_tdata;
                sel_keep  = s_axis_q0_tkeep;
            end
            2'd1: begin
                sel_valid = s_axis_q1_tvalid;
                sel_last  = s_axis_q1_tlast;
                sel_data  = s_axis_q1_tdata;
                sel_keep  = s_axis_q1_tkeep;
            end
            2'd2: begin
                sel_valid = s_axis_q2_tvalid;
                sel_last  = s_axis_q2_tlast;
                sel_data  = s_axis_q2_tdata;
                sel_keep  = s_axis_q2_tkeep;
            end
            default: ;
        endcase
    end

    assign load = xfer_ready & sel_valid;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        starve_d = 1'b0;
        for (int i = 0; i < 3; i++) cnt_d[i] = cnt_q[i];
        unique case (state_q)
            ARB: begin
                if (|q_valid) begin
                    state_d  = TRANSFER;
                    grant_d  = pick;
                    starve_d = pick_forced;
                    for (int i = 0; i < 3; i++) begin
                        if (pick == 2'(i)) begin
                            cnt_d[i] = '0;
                        end else if (q_valid[i] && cnt_q[i] != CNT_MAX) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
            TRANSFER: begin
                if (load && sel_last) begin
                    state_d = ARB;
                    grant_d = 2'd3;
                end
            end
        endcase
    end

    // Payload is held after a drain; only the valid flag is cleared.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_last_d  = sel_last;
            out_data_d  = sel_data;
            out_keep_d  = sel_keep;
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            grant_q     <= 2'd3;
            starve_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            starve_q    <= starve_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign m_axis_tvalid       = out_valid_q;
    assign m_axis_tlast        = out_last_q;
    assign m_axis_tdata        = out_data_q;
    assign m_axis_tkeep        = out_keep_q;
    assign status_grant        = grant_q;
    assign status_busy         = (state_q == TRANSFER);
    assign status_starve_event = starve_q;

endmodule

// File: tb/tb_priority_frame_scheduler.sv
// Directed bench for priority_frame_scheduler (STARVE_LIMIT=2).
module tb_priority_frame_scheduler;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_axis_q0_tdata = '0, s_axis_q1_tdata = '0, s_axis_q2_tdata = '0;
    logic [7:0]  s_axis_q0_tkeep = '0, s_axis_q1_tkeep = '0, s_axis_q2_tkeep = '0;
    logic        s_axis_q0_tvalid = 1'b0, s_axis_q1_tvalid = 1'b0, s_axis_q2_tvalid = 1'b0;
    logic        s_axis_q0_tlast = 1'b0, s_axis_q1_tlast = 1'b0, s_axis_q2_tlast = 1'b0;
    logic        s_axis_q0_tready, s_axis_q1_tready, s_axis_q2_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [1:0]  status_grant;
    logic        status_busy;
    logic        status_starve_event;

    priority_frame_scheduler #(
        .AXIS_DATA_WIDTH(64),
        .AXIS_KEEP_WIDTH(8),
        .STARVE_LIMIT(2),
        .STARVE_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_q0_tdata(s_axis_q0_tdata), .s_axis_q0_tkeep(s_axis_q0_tkeep),
        .s_axis_q0_tvalid(s_axis_q0_tvalid), .s_axis_q0_tready(s_axis_q0_tready),
        .s_axis_q0_tlast(s_axis_q0_tlast),
        .s_axis_q1_tdata(s_axis_q1_tdata), .s_axis_q1_tkeep(s_axis_q1_tkeep),
        .s_axis_q1_tvalid(s_axis_q1_tvalid), .s_axis_q1_tready(s_axis_q1_tready),
        .s_axis_q1_tlast(s_axis_q1_tlast),
        .s_axis_q2_tdata(s_axis_q2_tdata), .s_axis_q2_tkeep(s_axis_q2_tkeep),
        .s_axis_q2_tvalid(s_axis_q2_tvalid), .s_axis_q2_tready(s_axis_q2_tready),
        .s_axis_q2_tlast(s_axis_q2_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .status_grant(status_grant), .status_busy(status_busy),
        .status_starve_event(status_starve_event)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fails  = 0;
    int    cyc      = 0;
    int    starve_n = 0;
    bit    rand_rdy = 1'b0;
    bit    hold_pend = 1'b0;
    beat_t hold_val;
    logic [1:0] prev_grant = 2'd3;

    beat_t src [3][$];
    beat_t exp_q [3][$];
    beat_t exp_seq [$];
    beat_t rx [$];
    int    rx_cyc [$];
    int    glog [$];
    int    starve_g [$];

    logic [2:0] tb_valid, tb_ready;
    assign tb_valid = {s_axis_q2_tvalid, s_axis_q1_tvalid, s_axis_q0_tvalid};
    assign tb_ready = {s_axis_q2_tready, s_axis_q1_tready, s_axis_q0_tready};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input int q, input int f, input int b, input int n);
        beat_t x;
        x.d = {2'(q), 14'(f), 16'(b), 32'hC0DE_0000 | 32'(n)};
        x.k = 8'(f + b + 1);
        x.l = (b == n - 1);
        return x;
    endfunction

    task automatic add_frame(input int q, input int f, input int n);
        for (int b = 0; b < n; b++) begin
            src[q].push_back(mk(q, f, b, n));
            exp_q[q].push_back(mk(q, f, b, n));
            exp_seq.push_back(mk(q, f, b, n));
        end
    endtask

    task automatic drive();
        beat_t h [3];
        for (int q = 0; q < 3; q++) h[q] = (src[q].size() > 0) ? src[q][0] : '0;
        s_axis_q0_tvalid = src[0].size() > 0;
        s_axis_q1_tvalid = src[1].size() > 0;
        s_axis_q2_tvalid = src[2].size() > 0;
        {s_axis_q0_tdata, s_axis_q0_tkeep, s_axis_q0_tlast} = h[0];
        {s_axis_q1_tdata, s_axis_q1_tkeep, s_axis_q1_tlast} = h[1];
        {s_axis_q2_tdata, s_axis_q2_tkeep, s_axis_q2_tlast} = h[2];
    endtask

    task automatic tick();
        logic [2:0] acc;
        beat_t cur;
        @(negedge clk);
        cyc++;
        acc = tb_valid & tb_ready;
        cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (hold_pend && !rst) chk("hold_stable", 128'(cur), 128'(hold_val));
        hold_pend = m_axis_tvalid && !m_axis_tready && !rst;
        hold_val  = cur;
        if (m_axis_tvalid && m_axis_tready) begin
            rx.push_back(cur);
            rx_cyc.push_back(cyc);
        end
        if (status_starve_event) begin
            starve_n++;
            starve_g.push_back(int'(status_grant));
        end
        if (prev_grant == 2'd3 && status_grant != 2'd3) glog.push_back(int'(status_grant));
        prev_grant = status_grant;
        @(posedge clk);
        #1;
        for (int q = 0; q < 3; q++) if (acc[q]) void'(src[q].pop_front());
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (!(src[0].size() == 0 && src[1].size() == 0 && src[2].size() == 0 &&
                 !m_axis_tvalid && !status_busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("timeout", 128'(1), 128'(0));
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, 128'(rx.size()), 128'(exp_seq.size()));
        for (int i = 0; i < rx.size() && i < exp_seq.size(); i++)
            chk({tag, "_beat"}, 128'(rx[i]), 128'(exp_seq[i]));
    endtask

    task automatic cmp_glog(input string tag, input int a [$]);
        chk({tag, "_n"}, 128'(glog.size()), 128'(a.size()));
        for (int i = 0; i < glog.size() && i < a.size(); i++)
            chk({tag, "_g"}, 128'(glog[i]), 128'(a[i]));
    endtask

    task automatic clr();
        rx.delete(); rx_cyc.delete(); glog.delete();
        exp_seq.delete(); starve_g.delete();
        starve_n = 0;
        for (int q = 0; q < 3; q++) exp_q[q].delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tvalid"}, 128'(m_axis_tvalid), 128'(0));
        chk({tag, "_tready"}, 128'(tb_ready), 128'(0));
        chk({tag, "_grant"}, 128'(status_grant), 128'(3));
        chk({tag, "_busy"}, 128'(status_busy), 128'(0));
        chk({tag, "_starve"}, 128'(status_starve_event), 128'(0));
    endtask

    task automatic do_reset();
        for (int q = 0; q < 3; q++) src[q].delete();
        drive();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        prev_grant = 2'd3;
    endtask

    initial begin
        int cur_q, qi;
        beat_t snap [$];

        // Reset state
        tick();
        tick();
        chk_reset("rst0");
        chk("rst0_tlast", 128'(m_axis_tlast), 128'(0));
        chk("rst0_tdata", 128'(m_axis_tdata), 128'(0));
        rst = 1'b0;
        tick();
        chk("idle_grant", 128'(status_grant), 128'(3));

        // Single 4-beat q2 frame, two-cycle first-beat latency
        clr();
        add_frame(2, 0, 4);
        drive();
        tick();
        chk("t1_v_c1", 128'(m_axis_tvalid), 128'(0));
        chk("t1_grant", 128'(status_grant), 128'(2));
        chk("t1_busy", 128'(status_busy), 128'(1));
        chk("t1_rdy", 128'(tb_ready), 128'(3'b100));
        tick();
        chk("t1_v_c2", 128'(m_axis_tvalid), 128'(1));
        run_idle(50);
        cmp_seq("t1");
        chk("t1_end_grant", 128'(status_grant), 128'(3));

        // q0 and q1 together: q0 frame first, one bubble, then q1
        clr();
        add_frame(0, 1, 3);
        add_frame(1, 1, 3);
        drive();
        run_idle(50);
        cmp_seq("t2");
        cmp_glog("t2", '{0, 1});
        if (rx_cyc.size() >= 4) chk("t2_gap", 128'(rx_cyc[3] - rx_cyc[2]), 128'(2));

        // q0 arrives mid-frame of a 5-beat q2 frame
        clr();
        add_frame(2, 2, 5);
        drive();
        tick();
        tick();
        tick();
        add_frame(0, 2, 2);
        drive();
        run_idle(60);
        cmp_seq("t3");
        cmp_glog("t3", '{2, 0});

        // Starvation promotion of q2 behind a stream of 1-beat q0 frames
        do_reset();
        clr();
        add_frame(0, 3, 1);
        add_frame(0, 4, 1);
        add_frame(2, 3, 1);
        add_frame(0, 5, 1);
        add_frame(0, 6, 1);
        add_frame(2, 4, 1);
        add_frame(0, 7, 1);
        drive();
        run_idle(80);
        cmp_seq("t4");
        cmp_glog("t4", '{0, 0, 2, 0, 0, 2, 0});
        chk("t4_pulses", 128'(starve_n), 128'(2));
        for (int i = 0; i < starve_g.size(); i++)
            chk("t4_pulse_q", 128'(starve_g[i]), 128'(2));

        // Random backpressure, 100 frames per queue
        clr();
        for (int f = 0; f < 100; f++)
            for (int q = 0; q < 3; q++) add_frame(q, 100 + f, int'($urandom_range(1, 4)));
        rand_rdy = 1'b1;
        drive();
        run_idle(20000);
        rand_rdy = 1'b0;
        m_axis_tready = 1'b1;
        cur_q = -1;
        foreach (rx[i]) begin
            qi = int'(rx[i].d[63:62]);
            if (cur_q >= 0) chk("t5_no_intlv", 128'(qi), 128'(cur_q));
            if (qi < 3 && exp_q[qi].size() > 0)
                chk("t5_beat", 128'(rx[i]), 128'(exp_q[qi].pop_front()));
            else
                chk("t5_extra", 128'(1), 128'(0));
            cur_q = rx[i].l ? -1 : qi;
        end
        for (int q = 0; q < 3; q++) chk("t5_missing", 128'(exp_q[q].size()), 128'(0));

        // Reset in the middle of a q1 frame
        clr();
        add_frame(1, 9, 4);
        drive();
        for (int n = 0; n < 20 && rx.size() < 1; n++) tick();
        chk("t6_started", 128'(rx.size()), 128'(1));
        rst = 1'b1;
        tick();
        chk_reset("t6_rst");
        rst = 1'b0;
        prev_grant = 2'd3;
        clr();
        snap = src[1];
        exp_seq = snap;
        run_idle(50);
        cmp_seq("t6");
        cmp_glog("t6", '{1});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/priority_frame_scheduler.md
Name: priority_frame_scheduler

Overview:
Frame-atomic scheduler that shares one AXI-Stream output between the three priority FIFOs (q0 highest, q2 lowest) in the data_processing scheduler path.
- Strict priority by default.
- Per-queue starvation counters promote a waiting lower-priority queue once it has been bypassed STARVE_LIMIT frames in a row.
- Output goes through a single registered stage so the module drives a registered tvalid/tdata downstream.

Parameters:
AXIS_DATA_WIDTH, 64, tdata width in bits
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
STARVE_LIMIT, 8, frames a waiting queue may be bypassed before forced grant (1..255)
STARVE_CNT_WIDTH, 8, width of each starvation counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axis_q0_tdata  in  AXIS_DATA_WIDTH  queue 0 data (highest priority)
s_axis_q0_tkeep  in  AXIS_KEEP_WIDTH  queue 0 keep
s_axis_q0_tvalid  in  1  queue 0 valid
s_axis_q0_tready  out  1  queue 0 ready
s_axis_q0_tlast  in  1  queue 0 end of frame
s_axis_q1_*  same five signals as q0, queue 1
s_axis_q2_*  same five signals as q0, queue 2 (lowest priority)
m_axis_tdata  out  AXIS_DATA_WIDTH  scheduled data
m_axis_tkeep  out  AXIS_KEEP_WIDTH  scheduled keep
m_axis_tvalid  out  1  output valid (registered)
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  end of frame
status_grant  out  2  queue currently granted (0..2; 3 = none)
status_busy  out  1  1 while in TRANSFER
status_starve_event  out  1  one-cycle pulse when a grant is forced by starvation

Behaviour:
- Reset (rst sampled high on a clk edge):
  - State goes to ARB.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep=0.
  - All s_axis_qN_tready=0.
  - status_grant=3, status_busy=0, status_starve_event=0.
  - All starvation counters=0.
  - Reset mid-frame discards the output register content. The remainder of the interrupted frame is scheduled as a fresh frame; no recovery is attempted.
- States:
  - ARB: all tready=0. Waits for any tvalid. On the cycle any tvalid=1, it registers the grant and moves to TRANSFER. A valid input is therefore first accepted one cycle after ARB sees it.
  - TRANSFER: only the granted queue sees tready, where tready = m_axis_tready | ~m_axis_tvalid. The accepted beat loads the output register on that edge. When the beat accepted from the granted queue has tlast=1, the state returns to ARB. This costs one bubble cycle between frames.
- Grant selection in ARB, among queues with tvalid=1:
  1. If any such queue has counter >= STARVE_LIMIT, grant the lowest-index starved queue and pulse status_starve_event on the cycle the grant registers.
  2. Otherwise grant the lowest-index valid queue.
- Counter update, once per grant, on the same edge the grant registers:
  - The granted queue's counter resets to 0.
  - Every other queue with tvalid=1 at that ARB cycle increments, saturating at 2^STARVE_CNT_WIDTH-1.
  - Queues not valid keep their value.
  - q0's counter is never used for forcing, since q0 always wins on priority; it is still maintained.
- Frame atomicity: no grant change is allowed before tlast is accepted, regardless of higher-priority tvalid. An upstream valid gap inside a frame holds TRANSFER with m_axis_tvalid dropping once the register drains.
- Output register:
  - Loads on (granted tvalid & tready).
  - Clears m_axis_tvalid on (m_axis_tready & no new load).
  - Sustains 1 beat/cycle under continuous ready.
  - Backpressure: when m_axis_tready=0 and m_axis_tvalid=1, the granted tready=0 and the register holds.
- Simultaneous events: if tlast is accepted while the register is also draining, both happen that edge and the state enters ARB.
- Latency: input beat to m_axis_tvalid is 1 cycle. Frame-to-frame gap is at least 1 cycle.
- Status:
  - status_grant is the registered grant; it returns to 3 on the edge entering ARB.
  - status_busy = (state==TRANSFER).

Test Plan:
- Single q2 frame, 4 beats, m_axis_tready=1 -> output 4 beats in order, tlast on beat 4, first m_axis_tvalid 2 cycles after q2 tvalid rises, status_grant=2 during transfer.
- q0 and q1 both valid with 3-beat frames -> q0 frame fully output first, one bubble, then q1 frame. q1 counter=1 after first grant, 0 after its own grant.
- q0 asserts tvalid mid-way through a 5-beat q2 frame -> q2 frame completes uninterrupted, then q0 is granted.
- STARVE_LIMIT=2, q0 continuously valid with 1-beat frames, q2 valid -> grants q0, q0, q2. status_starve_event pulses exactly once on the q2 grant; q2 counter returns to 0.
- Random m_axis_tready at 50%, 3 queues, 100 frames each -> all beats delivered, no loss/duplication, no interleaving within any frame, tdata stable while tvalid & ~tready.
- rst asserted during beat 2 of a q1 frame -> next cycle m_axis_tvalid=0, all tready=0, status_grant=3, counters 0. Scheduling resumes from ARB after rst deasserts.
